// File: rtl/uart_tx_port_if.sv
// CPU bus bundle for the UART transmitter port.
// The CPU side drives the strobes; the UART answers with ready/data_out.
interface uart_tx_port_if #(
   parameter int size_addr = 2
);
   logic                 select;
   logic                 read;
   logic                 write;
   logic [size_addr-1:0] address;
   logic [7:0]           data_in;
   logic [7:0]           data_out;
   logic                 ready;

   modport master (
      output select, read, write, address, data_in,
      input  data_out, ready
   );

   modport slave (
      input  select, read, write, address, data_in,
      output data_out, ready
   );
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Registers: 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 reserved.
module uart_tx_port #(
   parameter int         size_addr = 2,
   parameter int         depth_log = 2,
   parameter logic [7:0] div_init  = 8'd15
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_port_if.slave bus,
   output logic          tx
);
   localparam int depth = 1 << depth_log;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic                 req, wr_en, rd_en;
   logic [7:0]           rdata;
   logic [7:0]           divisor;
   logic                 overflow;
   logic [7:0]           mem [depth];
   logic [depth_log-1:0] wptr, rptr;
   logic [depth_log:0]   count;
   logic                 empty, full, busy;
   logic                 push, drop, pop;
   logic                 tick;
   state_t               state, state_n;
   logic [7:0]           shift, shift_n;
   logic [7:0]           timer, timer_n;
   logic [7:0]           reload, reload_n;
   logic [2:0]           idx, idx_n;
   logic                 tx_n;

   // The ready cycle masks the request so a held strobe is served once.
   assign req   = bus.select && (bus.read || bus.write) && !bus.ready;
   assign wr_en = req && bus.write;
   assign rd_en = req && !bus.write;

   assign empty = (count == '0);
   assign full  = (count == (depth_log+1)'(depth));
   assign busy  = (state != IDLE) || !empty;
   assign push  = wr_en && (bus.address == '0) && !full;
   assign drop  = wr_en && (bus.address == '0) && full;
   assign tick  = (timer == '0);

   // Read mux; unmapped and write-only locations read as zero.
   always_comb begin
      rdata = '0;
      case (bus.address)
         size_addr'(1): rdata = {4'b0, overflow, empty, full, busy};
         size_addr'(2): rdata = divisor;
         default:       rdata = '0;
      endcase
   end

   // Bus response: one-cycle ready, data_out zero outside ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.ready    <= 1'b0;
         bus.data_out <= '0;
      end else begin
         bus.ready    <= req;
         bus.data_out <= rd_en ? rdata : '0;
      end
   end

   // Divisor register and sticky overflow flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         divisor  <= div_init;
         overflow <= 1'b0;
      end else begin
         if (wr_en && bus.address == size_addr'(2))
            divisor <= bus.data_in;
         if (drop)
            overflow <= 1'b1;
         else if (rd_en && bus.address == size_addr'(1))
            overflow <= 1'b0;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents are meaningless once the pointers reset.
   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= bus.data_in;
   end

   // Transmitter state, bit timer and registered line output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         shift  <= '0;
         timer  <= '0;
         reload <= '0;
         idx    <= '0;
         tx     <= 1'b1;
      end else begin
         state  <= state_n;
         shift  <= shift_n;
         timer  <= timer_n;
         reload <= reload_n;
         idx    <= idx_n;
         tx     <= tx_n;
      end
   end

   // Frame sequencing; STOP reloads directly so queued bytes run back to back.
   always_comb begin
      state_n  = state;
      shift_n  = shift;
      timer_n  = timer;
      reload_n = reload;
      idx_n    = idx;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               shift_n  = mem[rptr];
               reload_n = divisor;
               timer_n  = divisor;
               state_n  = START;
            end
         end
         START: begin
            if (tick) begin
               timer_n = reload;
               idx_n   = '0;
               state_n = DATA;
            end else begin
               timer_n = timer - 8'd1;
            end
         end
         DATA: begin
            if (tick) begin
               timer_n = reload;
               shift_n = {1'b0, shift[7:1]};
               if (idx == 3'd7)
                  state_n = STOP;
               else
                  idx_n = idx + 3'd1;
            end else begin
               timer_n = timer - 8'd1;
            end
         end
         STOP: begin
            if (tick) begin
               if (!empty) begin
                  pop      = 1'b1;
                  shift_n  = mem[rptr];
                  reload_n = divisor;
                  timer_n  = divisor;
                  state_n  = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               timer_n = timer - 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Line level follows the state being entered.
   always_comb begin
      tx_n = 1'b1;
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         default: tx_n = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port: bus handshake, status,
// frame shape and timing, FIFO overflow, divisor change, reset.
module tb_uart_tx_port;
   logic clk;
   logic reset;
   logic tx;
   int   n_cmp;
   int   n_bad;

   logic [7:0] exp_b [8];
   int         exp_p [8];

   uart_tx_port_if #(.size_addr(2)) bus ();

   uart_tx_port #(
      .size_addr(2),
      .depth_log(2),
      .div_init (8'd15)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus),
      .tx   (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.select  = 1'b1;
      bus.write   = 1'b1;
      bus.address = a;
      bus.data_in = d;
      @(negedge clk);
      check("wr_ready", bus.ready, 1'b1);
      bus.select = 1'b0;
      bus.write  = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, input logic [7:0] e,
                         input string tag);
      @(negedge clk);
      bus.select  = 1'b1;
      bus.read    = 1'b1;
      bus.address = a;
      @(negedge clk);
      check("rd_ready", bus.ready, 1'b1);
      check(tag, bus.data_out, e);
      bus.select = 1'b0;
      bus.read   = 1'b0;
   endtask

   // Samples the first and last clock of every bit, continuously
   // across n frames, starting at the first falling edge of tx.
   task automatic capture(input int n);
      bit         seen;
      logic [9:0] wa, wb, ex;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (tx == 1'b0)
            seen = 1'b1;
      end
      if (!seen) begin
         check("start_seen", 0, 1);
      end else begin
         for (int f = 0; f < n; f++) begin
            ex = {1'b1, exp_b[f], 1'b0};
            wa = '0;
            wb = '0;
            for (int k = 0; k < 10; k++) begin
               for (int c = 0; c < exp_p[f]; c++) begin
                  if (!(f == 0 && k == 0 && c == 0))
                     @(negedge clk);
                  if (c == 0)
                     wa[k] = tx;
                  if (c == exp_p[f] - 1)
                     wb[k] = tx;
               end
            end
            check($sformatf("frame%0d_head", f), wa, ex);
            check($sformatf("frame%0d_tail", f), wb, ex);
         end
      end
   endtask

   initial begin
      int  r1, r2, r3, pulses, lows;
      bit  seen;
      n_cmp = 0;
      n_bad = 0;
      reset       = 1'b1;
      bus.select  = 1'b0;
      bus.read    = 1'b0;
      bus.write   = 1'b0;
      bus.address = '0;
      bus.data_in = '0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", bus.ready, 1'b0);
      check("rst_dout", bus.data_out, 8'h00);
      check("rst_tx_idle", tx, 1'b1);
      bus_rd(2'd1, 8'h04, "rst_status");
      bus_rd(2'd2, 8'h0F, "rst_divisor");
      bus_rd(2'd3, 8'h00, "reserved_rd");
      bus_rd(2'd0, 8'h00, "txdata_rd");
      @(negedge clk);
      check("dout_idle", bus.data_out, 8'h00);

      // Single frame 0xA5 at 4 clocks per bit.
      bus_wr(2'd2, 8'd3);
      bus_rd(2'd2, 8'h03, "div_rb");
      exp_b[0] = 8'hA5;
      exp_p[0] = 4;
      fork
         capture(1);
         begin
            bus_wr(2'd0, 8'hA5);
            bus_rd(2'd1, 8'h05, "status_busy");
         end
      join
      bus_rd(2'd1, 8'h04, "status_done");

      // Strobe held over the ready cycle: one pulse, one push.
      exp_b[0] = 8'h5A;
      exp_p[0] = 4;
      fork
         capture(1);
         begin
            @(negedge clk);
            bus.select  = 1'b1;
            bus.write   = 1'b1;
            bus.address = 2'd0;
            bus.data_in = 8'h5A;
            @(negedge clk);
            r1 = int'(bus.ready);
            @(negedge clk);
            r2 = int'(bus.ready);
            bus.select = 1'b0;
            bus.write  = 1'b0;
            @(negedge clk);
            r3 = int'(bus.ready);
            check("hold_first", r1, 1);
            check("hold_pulses", r1 + r2 + r3, 1);
         end
      join
      bus_rd(2'd1, 8'h04, "hold_one_push");

      // Unselected strobes are ignored.
      @(negedge clk);
      bus.select  = 1'b0;
      bus.write   = 1'b1;
      bus.address = 2'd0;
      bus.data_in = 8'hEE;
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         pulses += int'(bus.ready);
      end
      bus.write = 1'b0;
      check("nosel_ready", pulses, 0);
      bus_rd(2'd1, 8'h04, "nosel_status");

      // Divisor 0: fill FIFO, overflow, contiguous frames.
      bus_wr(2'd2, 8'd0);
      for (int i = 0; i < 6; i++) begin
         exp_b[i] = 8'h11 * (i + 1);
         exp_p[i] = 1;
      end
      fork
         capture(6);
         begin
            bus_wr(2'd0, 8'h11);
            bus_wr(2'd0, 8'h22);
            bus_wr(2'd0, 8'h33);
            bus_wr(2'd0, 8'h44);
            bus_wr(2'd0, 8'h55);
            bus_rd(2'd1, 8'h03, "status_full");
            bus_wr(2'd0, 8'h66);
            bus_wr(2'd0, 8'h77);
            bus_rd(2'd1, 8'h0B, "status_ovf");
            bus_rd(2'd1, 8'h03, "status_ovf_clr");
         end
      join
      bus_rd(2'd1, 8'h04, "status_drained");

      // Divisor write mid-frame applies to the next frame only.
      bus_wr(2'd2, 8'd3);
      exp_b[0] = 8'h96;
      exp_p[0] = 4;
      exp_b[1] = 8'h3C;
      exp_p[1] = 8;
      fork
         capture(2);
         begin
            bus_wr(2'd0, 8'h96);
            bus_wr(2'd0, 8'h3C);
            bus_wr(2'd2, 8'd7);
         end
      join
      bus_rd(2'd1, 8'h04, "divchg_status");
      bus_rd(2'd2, 8'h07, "divchg_rb");

      // Reset during data bit 3 of 0xF0 with a second byte queued.
      bus_wr(2'd2, 8'd3);
      seen = 1'b0;
      fork
         begin
            bus_wr(2'd0, 8'hF0);
            bus_wr(2'd0, 8'h81);
         end
         begin
            for (int i = 0; i < 100 && !seen; i++) begin
               @(negedge clk);
               if (tx == 1'b0)
                  seen = 1'b1;
            end
         end
      join
      check("mid_start_seen", seen, 1'b1);
      repeat (16) @(negedge clk);
      check("mid_bit3", tx, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_tx", tx, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      bus_rd(2'd1, 8'h04, "post_rst_status");
      bus_rd(2'd2, 8'h0F, "post_rst_div");
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx == 1'b0)
            lows++;
      end
      check("post_rst_quiet", lows, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped UART transmitter that acts as a responder on the CPU bus (read/write/address/data/ready), alongside rom and ram.
- Accepts bytes from the CPU into a small FIFO and serialises them on `tx` as 8N1 frames at a programmable bit period.
- Exposes status to the CPU so firmware can poll for free space and idle.
- Selected by the top level through `select`, decoded from the upper address bits.

Parameters:
- size_addr, 2, register address width (4 registers).
- depth_log, 2, log2 of FIFO depth (4 entries).
- div_init, 8'd15, reset value of the divisor register; one bit period = divisor+1 clocks.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- select  input  1  block is addressed this cycle.
- read  input  1  CPU read strobe.
- write  input  1  CPU write strobe.
- address  input  size_addr  register index.
- data_in  input  8  write data from CPU.
- data_out  output  8  read data to CPU; 0 when ready low.
- ready  output  1  one-cycle transaction-complete pulse.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset (asynchronous, active-high): ready=0, data_out=0, tx=1, FIFO empty, overflow=0, divisor=div_init, FSM=IDLE, counters=0.
- Request = select && (read || write) && !ready, sampled on the rising clk edge.
- ready rises on the edge after a sampled request and stays high exactly 1 cycle.
- A request held across the ready cycle is not re-sampled, so one transaction takes at most 2 cycles.
- read && write together is treated as a write.
- Write side effects are applied at the sampling edge.
- data_out is registered, valid only while ready=1, and 0 otherwise, so the top level can OR/mux it.
- Register map:
  - 0 TXDATA: write pushes data_in into the FIFO; read returns 0.
  - 1 STATUS: read returns {4'b0, overflow, empty, full, busy}, and the read clears overflow. Writes are ignored.
  - 2 DIVISOR: read/write 8 bits.
  - 3: reserved; reads 0, writes ignored.
- FIFO:
  - Depth 2^depth_log.
  - Write pointer, read pointer and count of width depth_log+1; pointers wrap modulo depth.
  - Push when full: byte dropped, overflow set (sticky until a STATUS read).
  - Push and pop on the same edge: both happen, and count is unchanged.
  - Push when empty while the FSM is in IDLE: the byte is popped no earlier than the following edge.
- busy = (FSM != IDLE) || !empty.
- TX FSM:
  - IDLE: tx=1. If FIFO not empty, pop into the shift register, latch divisor into the bit timer reload, go to START.
  - START: tx=0 for one bit period, then DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. After each bit period, shift right. After bit 7, go to STOP.
  - STOP: tx=1 for one bit period, then IDLE. Back-to-back bytes therefore have no extra idle bit.
- Bit timer loads the latched divisor and counts down to 0; a bit period lasts (latched divisor)+1 clocks.
- A DIVISOR write mid-frame affects only the next frame.
- Divisor 0 gives 1 clock per bit, which is legal.
- Frame length = 10 × (div+1) clocks.
- Latency: with the FIFO empty and FSM idle, a TXDATA write at edge N gives tx falling (start bit) no later than edge N+2.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously), and the FIFO contents are discarded.

Test Plan:
- Reset with default divisor 15 → tx=1, ready=0, data_out=0; STATUS read returns 8'h04 (empty), DIVISOR read returns 8'h0F.
- Write DIVISOR=3, then TXDATA=8'hA5 → tx shows start 0, then bits 1,0,1,0,0,1,0,1 (LSB first), then stop 1, each bit 4 clocks, 40 clocks total. STATUS during the frame = 8'h05; after the frame = 8'h04.
- Bus handshake: hold write with select for 3 cycles → exactly one ready pulse in cycle 2 and exactly one FIFO push. select=0 → ready never asserts.
- With DIVISOR=0, write 5 bytes while the first is still transmitting:
  - STATUS shows full (bit1) while 4 entries are queued.
  - The 5th byte written while full is dropped and sets overflow (bit3).
  - The first STATUS read returns overflow=1; a second read returns overflow=0.
  - Exactly 4 or 5 frames follow, contiguously with no gaps.
- Write DIVISOR=7 in the middle of a frame sent with div=3 → the current frame keeps 4 clocks/bit, and the next frame uses 8 clocks/bit.
- Assert reset during DATA bit 3 → tx=1 in the same cycle, FIFO empty. After release, STATUS=8'h04 and no further frames are sent.
